// File: rtl/sym_dn_pkg.sv
// rtl/sym_dn_pkg.sv - shared types and sizing helpers for the ping-pong decision-node LUT
//
// Purpose: load FSM state encoding and the page-depth helper.
// No ports.
package sym_dn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Entries per page for a given page address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sym_dn_lut_page.sv
// rtl/sym_dn_lut_page.sv - one LUT page: single sync write port, RD_PORTS async read ports
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   ADDR_W           write address
//   wdata  in   DATA_W           write data
//   raddr  in   RD_PORTS*ADDR_W  read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rdata  out  RD_PORTS*DATA_W  combinational read data, port k = [k*DATA_W +: DATA_W]
module sym_dn_lut_page
  import sym_dn_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 1,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata
);

  localparam int DEPTH = depth_of(ADDR_W);

  // Contents are intentionally not reset; the top gates reads with lut_valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    assign rdata[k*DATA_W +: DATA_W] = mem_q[raddr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/sym_dn_rank_pp.sv
// rtl/sym_dn_rank_pp.sv - double-buffered decision-node symbol LUT with streamed shadow reload
//
// Ports:
//   write_clk    in   single clock for all logic
//   rst          in   synchronous active-high reset
//   rd_addr      in   RD_PORTS*ADDR_W  read addresses, port k = [k*ADDR_W +: ADDR_W]
//   lut_data     out  RD_PORTS*DATA_W  registered read data, port k = [k*DATA_W +: DATA_W]
//   load_start   in   begin reloading the shadow page
//   load_abort   in   discard the load in progress (no swap)
//   load_valid   in   load beat valid
//   load_data    in   DATA_W           load beat payload, entry N = beat N
//   load_ready   out  high in LOAD
//   load_done    out  one-cycle pulse the cycle after COMMIT
//   busy         out  high in LOAD or COMMIT
//   active_page  out  page currently served to the readers
//   lut_valid    out  set by the first completed commit
module sym_dn_rank_pp
  import sym_dn_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 1,
  parameter int RD_PORTS = 2
) (
  input  logic                         write_clk,
  input  logic                         rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   lut_data,
  input  logic                         load_start,
  input  logic                         load_abort,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  output logic                         load_ready,
  output logic                         load_done,
  output logic                         busy,
  output logic                         active_page,
  output logic                         lut_valid
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                       state_q, state_d;
  logic                         active_page_q, active_page_d;
  logic                         lut_valid_q, lut_valid_d;
  logic [ADDR_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic                         load_done_q, load_done_d;
  logic [RD_PORTS*DATA_W-1:0]   lut_data_q, lut_data_d;

  logic                         beat_ok;
  logic [1:0]                   page_we;
  logic [RD_PORTS*DATA_W-1:0]   page0_rdata, page1_rdata;

  // Load FSM. Abort wins over both beat acceptance and the swap.
  always_comb begin
    state_d       = state_q;
    active_page_d = active_page_q;
    lut_valid_d   = lut_valid_q;
    wr_cnt_d      = wr_cnt_q;
    load_done_d   = 1'b0;
    beat_ok       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_abort) begin
          state_d = ST_IDLE;
        end else if (load_valid) begin
          beat_ok  = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_ADDR) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (!load_abort) begin
          active_page_d = ~active_page_q;
          lut_valid_d   = 1'b1;
          load_done_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the shadow page (the one not being served) is ever written.
  assign page_we[0] = beat_ok &  active_page_q;
  assign page_we[1] = beat_ok & ~active_page_q;

  sym_dn_lut_page #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_PORTS (RD_PORTS)
  ) u_page0 (
    .clk   (write_clk),
    .we    (page_we[0]),
    .waddr (wr_cnt_q),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (page0_rdata)
  );

  sym_dn_lut_page #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_PORTS (RD_PORTS)
  ) u_page1 (
    .clk   (write_clk),
    .we    (page_we[1]),
    .waddr (wr_cnt_q),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (page1_rdata)
  );

  // Reads use the pre-edge active page, so a read in the COMMIT cycle still sees old data.
  always_comb begin
    lut_data_d = '0;
    if (lut_valid_q) begin
      lut_data_d = active_page_q ? page1_rdata : page0_rdata;
    end
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      active_page_q <= 1'b0;
      lut_valid_q   <= 1'b0;
      wr_cnt_q      <= '0;
      load_done_q   <= 1'b0;
      lut_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      active_page_q <= active_page_d;
      lut_valid_q   <= lut_valid_d;
      wr_cnt_q      <= wr_cnt_d;
      load_done_q   <= load_done_d;
      lut_data_q    <= lut_data_d;
    end
  end

  assign lut_data    = lut_data_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
  assign load_done   = load_done_q;
  assign active_page = active_page_q;
  assign lut_valid   = lut_valid_q;

endmodule
